// File: rtl/sdram_test_monitor_if.sv
// Status bus between the SDRAM tester and its LED monitor.
// The tester side (master) drives run/fail/clear; the monitor side (slave)
// returns the LED pattern, the saturating error count and the sticky fail flag.
`timescale 1ns/1ps
interface sdram_test_monitor_if #(
    parameter int ERR_BITS = 8
);
    logic                run;
    logic                fail;
    logic                clear;
    logic [1:0]          led;
    logic [ERR_BITS-1:0] errors;
    logic                failSeen;

    modport master (
        output run, fail, clear,
        input  led, errors, failSeen
    );

    modport slave (
        input  run, fail, clear,
        output led, errors, failSeen
    );
endinterface

// File: rtl/sdram_test_monitor.sv
// SDRAM tester status monitor: counts fail rising edges (saturating), keeps a
// sticky fail flag and stretches each fail into a visible blink window on the
// status LEDs.
// Build option: define SDRAM_MONITOR_ERRCODE_EN to drive led[0] from a
// blink-code FSM that flashes the error count (capped at CODE_MAX) per frame.
`timescale 1ns/1ps
module sdram_test_monitor #(
    parameter int BLINK_BITS = 24,
    parameter int HOLD_BITS  = 28,
    parameter int ERR_BITS   = 8,
    parameter int CODE_MAX   = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    sdram_test_monitor_if.slave   bus
);
    // Window-off value: only the MSB set, so the stretch counter is parked.
    localparam logic [HOLD_BITS-1:0] HOLD_OFF = {1'b1, {(HOLD_BITS-1){1'b0}}};

    logic [BLINK_BITS-1:0] bc_reg;
    logic                  failD_reg;
    logic [ERR_BITS-1:0]   errors_reg;
    logic                  failSeen_reg;
    logic [HOLD_BITS-1:0]  hold_reg;
    logic [1:0]            led_reg;
    logic                  led0_next;

    logic fail_rise;
    logic on;
    logic blink;
    logic flash;

    assign fail_rise = bus.fail & ~failD_reg;
    assign on        = ~hold_reg[HOLD_BITS-1];
    assign blink     = bc_reg[BLINK_BITS-1];
    assign flash     = on & blink;

    // Free-running blink counter; wraps naturally at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) bc_reg <= '0;
        else       bc_reg <= bc_reg + 1'b1;
    end

    // Fail edge detect, saturating error count and sticky flag; clear wins
    // over history but a coincident rising edge is still counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            failD_reg    <= 1'b0;
            errors_reg   <= '0;
            failSeen_reg <= 1'b0;
        end else begin
            failD_reg <= bus.fail;
            if (bus.clear) begin
                errors_reg   <= fail_rise ? ERR_BITS'(1) : '0;
                failSeen_reg <= fail_rise;
            end else if (fail_rise) begin
                if (~&errors_reg) errors_reg <= errors_reg + 1'b1;
                failSeen_reg <= 1'b1;
            end
        end
    end

    // Fail-stretch window: restart on every rising edge, run until MSB sets.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          hold_reg <= HOLD_OFF;
        else if (fail_rise) hold_reg <= '0;
        else if (on)        hold_reg <= hold_reg + 1'b1;
    end

`ifdef SDRAM_MONITOR_ERRCODE_EN
    localparam int N_BITS = $clog2(CODE_MAX + 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]        state_reg;
    logic [N_BITS-1:0] n_reg;
    logic [1:0]        gcnt_reg;
    logic [N_BITS-1:0] code_n;
    logic              tick;

    assign tick = &bc_reg[BLINK_BITS-2:0];

    // Flash count for a new frame: errors clamped to [1, CODE_MAX].
    always_comb begin
        code_n = N_BITS'(CODE_MAX);
        if (errors_reg == '0)                  code_n = N_BITS'(1);
        else if (int'(errors_reg) < CODE_MAX)  code_n = N_BITS'(errors_reg);
    end

    // Blink-code sequencer. The gap runs three ticks in GAP and its fourth
    // tick in IDLE, which also starts the next frame, so frames of 2n+4
    // ticks repeat back to back while failSeen stays set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            n_reg     <= '0;
            gcnt_reg  <= '0;
        end else if (bus.clear) begin
            state_reg <= ST_IDLE;
        end else if (tick) begin
            case (state_reg)
                ST_IDLE: if (failSeen_reg) begin
                    n_reg     <= code_n;
                    state_reg <= ST_ON;
                end
                ST_ON: begin
                    n_reg     <= n_reg - 1'b1;
                    state_reg <= ST_OFF;
                end
                ST_OFF: if (n_reg != '0) begin
                    state_reg <= ST_ON;
                end else begin
                    state_reg <= ST_GAP;
                    gcnt_reg  <= '0;
                end
                default: if (gcnt_reg == 2'd2) state_reg <= ST_IDLE;
                         else                  gcnt_reg  <= gcnt_reg + 1'b1;
            endcase
        end
    end

    // led[0] pattern for the current sequencer state.
    always_comb begin
        case (state_reg)
            ST_IDLE: led0_next = ~bus.run;
            ST_ON:   led0_next = 1'b1;
            default: led0_next = 1'b0;
        endcase
    end
`else
    // Both LEDs follow run, inverted together while the blink window flashes.
    always_comb begin
        led0_next = ~bus.run ^ flash;
    end
`endif

    // Registered LED drive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) led_reg <= 2'b10;
        else       led_reg <= {bus.run ^ flash, led0_next};
    end

    // While reset is held the LEDs show the plain run level straight away.
    assign bus.led      = reset ? {bus.run, ~bus.run} : led_reg;
    assign bus.errors   = errors_reg;
    assign bus.failSeen = failSeen_reg;
endmodule
